// File: rtl/screen_text_reveal_pkg.sv
// Shared types and screen layouts for the frame-synchronous text reveal screens.
// Line layouts are packed arrays so a whole screen can be passed as one parameter.
package screen_text_reveal_pkg;

    localparam int MAX_LINES = 8;
    localparam logic [7:0] COLOR_WHITE = 8'hFF;

    typedef struct packed {
        logic [10:0] top_left_x;
        logic [10:0] top_left_y;
        logic [3:0]  word_size;
        logic [3:0]  letters;
    } line_cfg_t;

    typedef line_cfg_t [MAX_LINES-1:0] line_cfg_arr_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REVEAL = 2'd1,
        HOLD   = 2'd2
    } reveal_state_t;

    // Word colour per line index; index 0 is the rightmost entry.
    localparam logic [MAX_LINES-1:0][7:0] LINE_COLORS =
        {8'h92, 8'h6D, 8'hFC, 8'h1F, 8'hE3, 8'h03, 8'h1C, 8'hE0};

    function automatic line_cfg_t mk_line(input int x, input int y, input int size, input int letters);
        line_cfg_t c;
        c.top_left_x = 11'(x);
        c.top_left_y = 11'(y);
        c.word_size  = 4'(size);
        c.letters    = 4'(letters);
        return c;
    endfunction

    function automatic line_cfg_arr_t welcome_lines();
        line_cfg_arr_t a;
        a    = '0;
        a[0] = mk_line(200, 120, 15, 7);
        a[1] = mk_line(260, 220, 12, 2);
        a[2] = mk_line(180, 320, 10, 12);
        return a;
    endfunction

    function automatic line_cfg_arr_t gameover_lines();
        line_cfg_arr_t a;
        a    = '0;
        a[0] = mk_line(220, 160, 15, 4);
        a[1] = mk_line(220, 240, 15, 4);
        a[2] = mk_line(170, 340, 10, 13);
        return a;
    endfunction

    localparam line_cfg_arr_t WELCOME_LINES  = welcome_lines();
    localparam line_cfg_arr_t GAMEOVER_LINES = gameover_lines();

endpackage

// File: rtl/screen_reveal_ctrl.sv
// Reveal sequencer: IDLE/REVEAL/HOLD FSM, frame and blink counters and skip latch.
// All progress happens on start-of-frame cycles so a frame is never redrawn half-changed.
module screen_reveal_ctrl
    import screen_text_reveal_pkg::*;
#(
    parameter int NUM_LINES       = 3,
    parameter int FRAMES_PER_LINE = 30,
    parameter bit BLINK_EN        = 1'b1,
    parameter int BLINK_LINE      = NUM_LINES - 1,
    parameter int BLINK_FRAMES    = 32
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic                 startOfFrame,
    input  logic                 enable,
    input  logic                 skip,
    output logic [NUM_LINES-1:0] lineVisible,
    output logic                 revealDone
);

    localparam int FW = (FRAMES_PER_LINE > 1) ? $clog2(FRAMES_PER_LINE) : 1;
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int VW = $clog2(NUM_LINES + 1);

    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES_PER_LINE - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
    localparam logic [VW-1:0] LINES_ALL  = VW'(NUM_LINES);

    reveal_state_t state_q;
    logic [FW-1:0] frame_cnt_q;
    logic [BW-1:0] blink_cnt_q;
    logic [VW-1:0] vis_lines_q;
    logic          blink_on_q;
    logic          skip_pend_q;
    logic          reveal_done_q;

    // Sequencer state, counters and skip latch; enable low clears everything.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q       <= IDLE;
            frame_cnt_q   <= '0;
            blink_cnt_q   <= '0;
            vis_lines_q   <= '0;
            blink_on_q    <= 1'b1;
            skip_pend_q   <= 1'b0;
            reveal_done_q <= 1'b0;
        end else if (!enable) begin
            state_q       <= IDLE;
            frame_cnt_q   <= '0;
            blink_cnt_q   <= '0;
            vis_lines_q   <= '0;
            blink_on_q    <= 1'b1;
            skip_pend_q   <= 1'b0;
            reveal_done_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (startOfFrame) begin
                        frame_cnt_q <= '0;
                        vis_lines_q <= VW'(1);
                        if (NUM_LINES == 1) begin
                            state_q       <= HOLD;
                            blink_cnt_q   <= '0;
                            blink_on_q    <= 1'b1;
                            reveal_done_q <= 1'b1;
                        end else begin
                            state_q <= REVEAL;
                        end
                    end
                end
                REVEAL: begin
                    if (startOfFrame) begin
                        if (skip_pend_q || skip) begin
                            vis_lines_q   <= LINES_ALL;
                            skip_pend_q   <= 1'b0;
                            state_q       <= HOLD;
                            blink_cnt_q   <= '0;
                            blink_on_q    <= 1'b1;
                            reveal_done_q <= 1'b1;
                        end else if (frame_cnt_q == FRAME_LAST) begin
                            frame_cnt_q <= '0;
                            vis_lines_q <= vis_lines_q + VW'(1);
                            if ((vis_lines_q + VW'(1)) == LINES_ALL) begin
                                state_q       <= HOLD;
                                blink_cnt_q   <= '0;
                                blink_on_q    <= 1'b1;
                                reveal_done_q <= 1'b1;
                            end
                        end else begin
                            frame_cnt_q <= frame_cnt_q + FW'(1);
                        end
                    end else if (skip) begin
                        skip_pend_q <= 1'b1;
                    end
                end
                HOLD: begin
                    if (startOfFrame) begin
                        if (blink_cnt_q == BLINK_LAST) begin
                            blink_cnt_q <= '0;
                            blink_on_q  <= ~blink_on_q;
                        end else begin
                            blink_cnt_q <= blink_cnt_q + BW'(1);
                        end
                    end
                end
                default: begin
                    state_q       <= IDLE;
                    frame_cnt_q   <= '0;
                    blink_cnt_q   <= '0;
                    vis_lines_q   <= '0;
                    blink_on_q    <= 1'b1;
                    skip_pend_q   <= 1'b0;
                    reveal_done_q <= 1'b0;
                end
            endcase
        end
    end

    // Visibility mask decoded from registered state only; the blink line is gated in HOLD.
    always_comb begin
        lineVisible = '0;
        for (int i = 0; i < NUM_LINES; i++) begin
            if (VW'(i) < vis_lines_q) begin
                if (BLINK_EN && (i == BLINK_LINE) && (state_q == HOLD)) begin
                    lineVisible[i] = blink_on_q;
                end else begin
                    lineVisible[i] = 1'b1;
                end
            end else begin
                lineVisible[i] = 1'b0;
            end
        end
    end

    assign revealDone = reveal_done_q;

endmodule

// File: rtl/screen_text_word.sv
// Single text line: flags pixels inside the word's bounding box and supplies its colour.
// Purely combinational, so the pixel path adds no latency.
module screen_text_word
    import screen_text_reveal_pkg::*;
#(
    parameter line_cfg_t  CFG   = '0,
    parameter logic [7:0] COLOR = 8'hE0
) (
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    output logic        drawWord,
    output logic [7:0]  RGBWord
);

    localparam int         WIDTH = int'(CFG.word_size) * int'(CFG.letters);
    localparam logic [11:0] X0   = {1'b0, CFG.top_left_x};
    localparam logic [11:0] Y0   = {1'b0, CFG.top_left_y};
    localparam logic [11:0] X1   = 12'(int'(CFG.top_left_x) + WIDTH);
    localparam logic [11:0] Y1   = 12'(int'(CFG.top_left_y) + int'(CFG.word_size));

    // Bounding-box hit test against the half-open box [X0,X1) x [Y0,Y1).
    always_comb begin
        if (({1'b0, pixelX} >= X0) && ({1'b0, pixelX} < X1) &&
            ({1'b0, pixelY} >= Y0) && ({1'b0, pixelY} < Y1)) begin
            drawWord = 1'b1;
        end else begin
            drawWord = 1'b0;
        end
    end

    assign RGBWord = COLOR;

endmodule

// File: rtl/screen_text_reveal.sv
// Configurable multi-line text screen: lines appear one by one on frame boundaries,
// then an optional prompt line blinks; lowest-index visible line wins on overlap.
module screen_text_reveal
    import screen_text_reveal_pkg::*;
#(
    parameter int            NUM_LINES       = 3,
    parameter line_cfg_arr_t LINE_CFG        = WELCOME_LINES,
    parameter int            FRAMES_PER_LINE = 30,
    parameter bit            BLINK_EN        = 1'b1,
    parameter int            BLINK_LINE      = NUM_LINES - 1,
    parameter int            BLINK_FRAMES    = 32,
    parameter logic [7:0]    BG_COLOR        = COLOR_WHITE
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    input  logic        startOfFrame,
    input  logic        enable,
    input  logic        skip,
    output logic [7:0]  RGB_screen,
    output logic        revealDone
);

    logic [NUM_LINES-1:0]      line_visible_s;
    logic [NUM_LINES-1:0]      draw_s;
    logic [NUM_LINES-1:0][7:0] word_rgb_s;
    logic [7:0]                rgb_s;

    screen_reveal_ctrl #(
        .NUM_LINES      (NUM_LINES),
        .FRAMES_PER_LINE(FRAMES_PER_LINE),
        .BLINK_EN       (BLINK_EN),
        .BLINK_LINE     (BLINK_LINE),
        .BLINK_FRAMES   (BLINK_FRAMES)
    ) u_ctrl (
        .clk         (clk),
        .resetN      (resetN),
        .startOfFrame(startOfFrame),
        .enable      (enable),
        .skip        (skip),
        .lineVisible (line_visible_s),
        .revealDone  (revealDone)
    );

    for (genvar g = 0; g < NUM_LINES; g++) begin : g_word
        screen_text_word #(
            .CFG  (LINE_CFG[g]),
            .COLOR(LINE_COLORS[g])
        ) u_word (
            .pixelX  (pixelX),
            .pixelY  (pixelY),
            .drawWord(draw_s[g]),
            .RGBWord (word_rgb_s[g])
        );
    end

    // Priority composer: scanning from the top index down lets line 0 overwrite last.
    always_comb begin
        rgb_s = BG_COLOR;
        for (int i = NUM_LINES - 1; i >= 0; i--) begin
            rgb_s = (line_visible_s[i] && draw_s[i]) ? word_rgb_s[i] : rgb_s;
        end
    end

    assign RGB_screen = rgb_s;

endmodule

// File: tb/tb_screen_text_reveal.sv
// Bench for screen_text_reveal: three parameterisations share one stimulus stream and are
// checked against a frame-counting reference model, a hand-computed vector table and
// directed reset cases.
module tb_screen_text_reveal;
    import screen_text_reveal_pkg::*;

    localparam logic [7:0] W  = COLOR_WHITE;
    localparam logic [7:0] R0 = 8'hE0;
    localparam logic [7:0] R1 = 8'h1C;
    localparam logic [7:0] R2 = 8'h03;

    function automatic line_cfg_arr_t tb_lines();
        line_cfg_arr_t a;
        a    = '0;
        a[0] = mk_line(10, 10, 4, 3);
        a[1] = mk_line(16, 12, 4, 3);
        a[2] = mk_line(40, 40, 2, 4);
        return a;
    endfunction
    localparam line_cfg_arr_t TB_LINES = tb_lines();

    logic        clk;
    logic        resetN;
    logic [10:0] pixelX;
    logic [10:0] pixelY;
    logic        startOfFrame;
    logic        enable;
    logic        skip;
    logic [7:0]  rgb_a, rgb_b, rgb_c;
    logic        done_a, done_b, done_c;

    screen_text_reveal #(.NUM_LINES(3), .LINE_CFG(TB_LINES), .FRAMES_PER_LINE(4),
        .BLINK_EN(1'b1), .BLINK_LINE(2), .BLINK_FRAMES(2), .BG_COLOR(W)) u_a (
        .clk(clk), .resetN(resetN), .pixelX(pixelX), .pixelY(pixelY),
        .startOfFrame(startOfFrame), .enable(enable), .skip(skip),
        .RGB_screen(rgb_a), .revealDone(done_a));

    screen_text_reveal #(.NUM_LINES(3), .LINE_CFG(TB_LINES), .FRAMES_PER_LINE(4),
        .BLINK_EN(1'b0), .BLINK_LINE(2), .BLINK_FRAMES(2), .BG_COLOR(W)) u_b (
        .clk(clk), .resetN(resetN), .pixelX(pixelX), .pixelY(pixelY),
        .startOfFrame(startOfFrame), .enable(enable), .skip(skip),
        .RGB_screen(rgb_b), .revealDone(done_b));

    screen_text_reveal #(.NUM_LINES(1), .LINE_CFG(TB_LINES), .FRAMES_PER_LINE(4),
        .BLINK_EN(1'b0), .BLINK_LINE(0), .BLINK_FRAMES(2), .BG_COLOR(W)) u_c (
        .clk(clk), .resetN(resetN), .pixelX(pixelX), .pixelY(pixelY),
        .startOfFrame(startOfFrame), .enable(enable), .skip(skip),
        .RGB_screen(rgb_c), .revealDone(done_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: st 0=idle 1=reveal 2=hold, f = SOFs since reveal start,
    // h = SOFs since hold start, vis = number of lines revealed.
    typedef struct {
        int         n;
        int         fpl;
        int         bl;
        int         bf;
        bit         ben;
        logic [7:0] bg;
    } cfg_t;

    typedef struct {
        int st;
        int f;
        int h;
        bit sp;
        int vis;
    } mdl_t;

    cfg_t cfg_a, cfg_b, cfg_c;
    mdl_t m_a, m_b, m_c;
    int   n_cmp;
    int   n_fail;

    function automatic mdl_t mdl_reset();
        mdl_t r;
        r.st = 0; r.f = 0; r.h = 0; r.sp = 1'b0; r.vis = 0;
        return r;
    endfunction

    function automatic mdl_t mdl_next(input mdl_t m, input cfg_t c, input bit en, input bit sof, input bit sk);
        mdl_t r;
        r = m;
        if (!en) return mdl_reset();
        if (m.st == 0) begin
            if (sof) begin
                r.f = 0; r.h = 0; r.vis = 1;
                r.st = (c.n == 1) ? 2 : 1;
            end
        end else if (m.st == 1) begin
            if (sof) begin
                if (m.sp || sk) begin
                    r.vis = c.n; r.sp = 1'b0; r.st = 2; r.h = 0;
                end else begin
                    r.f = m.f + 1;
                    r.vis = 1 + r.f / c.fpl;
                    if (r.vis >= c.n) begin
                        r.vis = c.n; r.st = 2; r.h = 0;
                    end
                end
            end else if (sk) begin
                r.sp = 1'b1;
            end
        end else begin
            if (sof) r.h = m.h + 1;
        end
        return r;
    endfunction

    function automatic logic [7:0] mdl_rgb(input mdl_t m, input cfg_t c, input int px, input int py);
        for (int i = 0; i < c.n; i++) begin
            int x0, y0, w, s;
            bit shown;
            x0 = int'(TB_LINES[i].top_left_x);
            y0 = int'(TB_LINES[i].top_left_y);
            s  = int'(TB_LINES[i].word_size);
            w  = s * int'(TB_LINES[i].letters);
            shown = (i < m.vis);
            if (c.ben && i == c.bl && m.st == 2 && ((m.h / c.bf) % 2) == 1) shown = 1'b0;
            if (shown && px >= x0 && px < x0 + w && py >= y0 && py < y0 + s) return LINE_COLORS[i];
        end
        return c.bg;
    endfunction

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    // Called just after a falling edge: apply inputs, let them settle, compare to the model.
    task automatic drive(input bit en, input bit sof, input bit sk, input int px, input int py);
        enable = en; startOfFrame = sof; skip = sk;
        pixelX = 11'(px); pixelY = 11'(py);
        #2;
        chk8("model_rgb_a", rgb_a, mdl_rgb(m_a, cfg_a, px, py));
        chk8("model_rgb_b", rgb_b, mdl_rgb(m_b, cfg_b, px, py));
        chk8("model_rgb_c", rgb_c, mdl_rgb(m_c, cfg_c, px, py));
        chk1("model_done_a", done_a, m_a.st == 2);
        chk1("model_done_b", done_b, m_b.st == 2);
        chk1("model_done_c", done_c, m_c.st == 2);
    endtask

    task automatic advance();
        if (!resetN) begin
            m_a = mdl_reset(); m_b = mdl_reset(); m_c = mdl_reset();
        end else begin
            m_a = mdl_next(m_a, cfg_a, enable, startOfFrame, skip);
            m_b = mdl_next(m_b, cfg_b, enable, startOfFrame, skip);
            m_c = mdl_next(m_c, cfg_c, enable, startOfFrame, skip);
        end
        @(negedge clk);
    endtask

    typedef struct {
        bit         en;
        bit         sof;
        bit         sk;
        int         px;
        int         py;
        logic [7:0] ra;
        logic [7:0] rb;
        bit         d;
    } vec_t;

    function automatic vec_t v(input bit en, input bit sof, input bit sk, input int px, input int py,
                               input logic [7:0] ra, input logic [7:0] rb, input bit d);
        vec_t r;
        r.en = en; r.sof = sof; r.sk = sk; r.px = px; r.py = py; r.ra = ra; r.rb = rb; r.d = d;
        return r;
    endfunction

    vec_t tbl[30];
    int   pts_x[6];
    int   pts_y[6];

    initial begin
        n_cmp = 0; n_fail = 0;
        cfg_a.n = 3; cfg_a.fpl = 4; cfg_a.bl = 2; cfg_a.bf = 2; cfg_a.ben = 1'b1; cfg_a.bg = W;
        cfg_b = cfg_a; cfg_b.ben = 1'b0;
        cfg_c = cfg_b; cfg_c.n = 1; cfg_c.bl = 0;
        m_a = mdl_reset(); m_b = mdl_reset(); m_c = mdl_reset();
        pts_x = '{11, 18, 25, 41, 100, 46};
        pts_y = '{10, 12, 14, 40, 100, 41};

        // Points: (11,10) line0 only, (18,12) lines 0+1, (25,14) line1 only, (41,40) line2.
        tbl[0]  = v(1'b1, 1'b0, 1'b0, 11, 10, W,  W,  1'b0);
        tbl[1]  = v(1'b1, 1'b1, 1'b0, 11, 10, W,  W,  1'b0);
        tbl[2]  = v(1'b1, 1'b0, 1'b0, 11, 10, R0, R0, 1'b0);
        tbl[3]  = v(1'b1, 1'b0, 1'b0, 25, 14, W,  W,  1'b0);
        tbl[4]  = v(1'b1, 1'b1, 1'b0, 11, 10, R0, R0, 1'b0);
        tbl[5]  = v(1'b1, 1'b1, 1'b0, 18, 12, R0, R0, 1'b0);
        tbl[6]  = v(1'b1, 1'b1, 1'b0, 25, 14, W,  W,  1'b0);
        tbl[7]  = v(1'b1, 1'b1, 1'b0, 25, 14, W,  W,  1'b0);
        tbl[8]  = v(1'b1, 1'b0, 1'b0, 25, 14, R1, R1, 1'b0);
        tbl[9]  = v(1'b1, 1'b0, 1'b0, 18, 12, R0, R0, 1'b0);
        tbl[10] = v(1'b1, 1'b0, 1'b0, 41, 40, W,  W,  1'b0);
        tbl[11] = v(1'b1, 1'b1, 1'b0, 41, 40, W,  W,  1'b0);
        tbl[12] = v(1'b1, 1'b0, 1'b1, 41, 40, W,  W,  1'b0);
        tbl[13] = v(1'b1, 1'b0, 1'b0, 41, 40, W,  W,  1'b0);
        tbl[14] = v(1'b1, 1'b1, 1'b0, 41, 40, W,  W,  1'b0);
        tbl[15] = v(1'b1, 1'b0, 1'b0, 41, 40, R2, R2, 1'b1);
        tbl[16] = v(1'b1, 1'b1, 1'b1, 41, 40, R2, R2, 1'b1);
        tbl[17] = v(1'b1, 1'b1, 1'b0, 11, 10, R0, R0, 1'b1);
        tbl[18] = v(1'b1, 1'b0, 1'b0, 41, 40, W,  R2, 1'b1);
        tbl[19] = v(1'b1, 1'b0, 1'b0, 25, 14, R1, R1, 1'b1);
        tbl[20] = v(1'b1, 1'b1, 1'b0, 41, 40, W,  R2, 1'b1);
        tbl[21] = v(1'b1, 1'b1, 1'b0, 41, 40, W,  R2, 1'b1);
        tbl[22] = v(1'b1, 1'b0, 1'b0, 41, 40, R2, R2, 1'b1);
        tbl[23] = v(1'b0, 1'b0, 1'b0, 41, 40, R2, R2, 1'b1);
        tbl[24] = v(1'b0, 1'b0, 1'b0, 11, 10, W,  W,  1'b0);
        tbl[25] = v(1'b1, 1'b1, 1'b0, 11, 10, W,  W,  1'b0);
        tbl[26] = v(1'b1, 1'b0, 1'b0, 11, 10, R0, R0, 1'b0);
        tbl[27] = v(1'b1, 1'b0, 1'b0, 25, 14, W,  W,  1'b0);
        tbl[28] = v(1'b0, 1'b1, 1'b0, 11, 10, R0, R0, 1'b0);
        tbl[29] = v(1'b0, 1'b0, 1'b0, 11, 10, W,  W,  1'b0);

        resetN = 1'b0; enable = 1'b0; startOfFrame = 1'b0; skip = 1'b0;
        pixelX = 11'd0; pixelY = 11'd0;
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 11, 10);
        chk8("reset_rgb", rgb_a, W);
        chk1("reset_done", done_a, 1'b0);
        advance();
        resetN = 1'b1;

        for (int i = 0; i < 30; i++) begin
            drive(tbl[i].en, tbl[i].sof, tbl[i].sk, tbl[i].px, tbl[i].py);
            chk8($sformatf("tbl%0d_rgb_a", i), rgb_a, tbl[i].ra);
            chk8($sformatf("tbl%0d_rgb_b", i), rgb_b, tbl[i].rb);
            chk1($sformatf("tbl%0d_done_a", i), done_a, tbl[i].d);
            advance();
        end

        // Skip straight into HOLD, then pull reset asynchronously mid-cycle.
        drive(1'b1, 1'b1, 1'b0, 11, 10); advance();
        drive(1'b1, 1'b0, 1'b1, 11, 10); advance();
        drive(1'b1, 1'b1, 1'b0, 11, 10); advance();
        drive(1'b1, 1'b0, 1'b0, 11, 10);
        chk1("hold_before_reset", done_a, 1'b1);
        chk8("hold_rgb_before_reset", rgb_a, R0);
        resetN = 1'b0;
        #1;
        chk8("async_reset_rgb", rgb_a, W);
        chk1("async_reset_done_a", done_a, 1'b0);
        chk1("async_reset_done_c", done_c, 1'b0);
        advance();
        resetN = 1'b1;

        // NUM_LINES=1 instance must be in HOLD right after the first SOF.
        drive(1'b1, 1'b1, 1'b0, 11, 10); advance();
        drive(1'b1, 1'b0, 1'b0, 11, 10);
        chk1("single_line_hold", done_c, 1'b1);
        chk8("single_line_rgb", rgb_c, R0);
        advance();

        for (int k = 0; k < 4000; k++) begin
            int sel;
            int px;
            int py;
            sel = int'($urandom_range(0, 9));
            if (sel < 6) begin
                px = pts_x[sel]; py = pts_y[sel];
            end else begin
                px = int'($urandom_range(0, 60)); py = int'($urandom_range(0, 60));
            end
            drive($urandom_range(0, 149) != 0, $urandom_range(0, 5) == 0,
                  $urandom_range(0, 39) == 0, px, py);
            advance();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/screen_text_reveal.md
# screen_text_reveal

Parametrised multi-line text screen that generalises the fixed three-word welcome screen: NUM_LINES text lines, revealed one at a time on frame boundaries, with an optional blinking prompt line once fully shown. Sits in the screen-mux layer between the VGA pixel counters and the top-level RGB selector. It replaces per-screen hand-written word stacks (welcome, game-over, level-up) with one configurable block.

## Interface
- NUM_LINES, 3, number of text lines (1..8).
- LINE_CFG, WELCOME_LINES, package array of per-line {TOP_LEFT_X, TOP_LEFT_Y, WORD_SIZE, LETTERS}.
- FRAMES_PER_LINE, 30, frames between successive line reveals (>=1).
- BLINK_EN, 1, enables blinking of line BLINK_LINE in HOLD.
- BLINK_LINE, NUM_LINES-1, index of the blinking line.
- BLINK_FRAMES, 32, frames per blink half-period (>=1).
- BG_COLOR, COLOR_WHITE, background colour.

- clk  in  1  pixel clock; the block uses this single clock.
- resetN  in  1  asynchronous, active-low reset.
- pixelX  in  11  current pixel column.
- pixelY  in  11  current pixel row.
- startOfFrame  in  1  one-cycle pulse at frame start.
- enable  in  1  screen is active; low forces IDLE.
- skip  in  1  one-cycle pulse; request immediate full reveal.
- RGB_screen  out  8  composed pixel colour.
- revealDone  out  1  high while in HOLD.

## Operation
- FSM states: IDLE, REVEAL, HOLD. Reset: IDLE, visibleLines=0, frameCnt=0, blinkCnt=0, blinkOn=1, skipPending=0, revealDone=0.
- All state, counter and visibility updates happen only on cycles with startOfFrame=1. The only exceptions are enable low and skip latching. This prevents mid-frame tearing.
- IDLE: when enable=1 on an SOF cycle, go to REVEAL with visibleLines=1 and frameCnt=0.
- REVEAL, on each SOF:
  - If skipPending, set visibleLines=NUM_LINES, clear skipPending, go to HOLD.
  - Otherwise, if frameCnt==FRAMES_PER_LINE-1, set frameCnt=0 and visibleLines+=1. Go to HOLD when the new value equals NUM_LINES.
  - Otherwise frameCnt+=1.
  - With NUM_LINES=1, go directly to HOLD on the first SOF.
- skip: latched into skipPending on any cycle in REVEAL. Ignored in IDLE and HOLD. A skip on the same cycle as an SOF is applied on that SOF.
- HOLD: revealDone=1. On entry, blinkOn=1 and blinkCnt=0. Each SOF, blinkCnt counts to BLINK_FRAMES-1, then wraps to 0 and toggles blinkOn.
- enable=0 on any cycle: next cycle is IDLE with all registers at reset values. It takes priority over SOF and skip.
- Line i is drawn iff i<visibleLines, and additionally blinkOn=1 when BLINK_EN && i==BLINK_LINE && state==HOLD.
- Compose: the lowest-index drawn line whose drawWord is high supplies RGBWord. Otherwise BG_COLOR. In IDLE, output BG_COLOR.
- Widths: frameCnt $clog2(FRAMES_PER_LINE) bits (min 1), blinkCnt $clog2(BLINK_FRAMES) bits (min 1), visibleLines $clog2(NUM_LINES+1) bits. Counters never exceed their terminal value.

## Timing
- Control path: registered. A visibility change takes effect on the cycle after the SOF cycle, i.e. the first pixel of the new frame.
- Pixel path: no extra register in this block. RGB_screen latency equals the word instance latency.
- revealDone rises on the cycle after the SOF that enters HOLD. It falls on the cycle after enable drops.
- Reveal time without skip: (NUM_LINES-1)*FRAMES_PER_LINE frames after entering REVEAL.

## Structure
- Package defines: line_cfg_t struct (TOP_LEFT_X, TOP_LEFT_Y, WORD_SIZE, LETTERS), per-screen LINE_CFG arrays (WELCOME_LINES, GAMEOVER_LINES), and the reveal_state_t enum.
- Sub-module screen_reveal_ctrl contains the FSM, counters and skip latch, and outputs a lineVisible[NUM_LINES] mask plus revealDone.
- The top instantiates screen_reveal_ctrl plus a generate loop of NUM_LINES existing word instances, followed by the priority composer.

## Test plan
- Reset mid-HOLD: assert resetN=0 -> RGB_screen=BG_COLOR, revealDone=0, visibleLines=0 immediately (asynchronous).
- NUM_LINES=3, FRAMES_PER_LINE=4, enable=1 -> line0 drawn from frame 1, line1 from frame 5, line2 and revealDone=1 from frame 9. No change mid-frame.
- skip pulse mid-frame 2 of REVEAL -> all 3 lines visible starting the next frame, revealDone=1. A skip in HOLD has no effect.
- HOLD with BLINK_FRAMES=2 -> line2 pixels alternate word colour / BG_COLOR every 2 frames, while lines 0-1 stay steady. BLINK_EN=0 -> steady.
- enable dropped during REVEAL on a non-SOF cycle -> next cycle IDLE, BG_COLOR. Re-enable -> reveal restarts from line0.
- Overlapping lines 0 and 1 at the same pixel -> RGB_screen equals line0's RGBWord. NUM_LINES=1 -> HOLD after the first SOF.
